pipe_reg_skid: RTL and testbench
================================

# pipe_reg_skid

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It is a two-entry valid/ready pipeline register with a skid entry, a global stall input and a ROB-index-aware flush, carrying an opaque payload of any width. It sits between any two core stages, e.g. ID→EX or EX→MEM. Under a branch or exception redirect it removes only the instructions younger than the redirecting one, instead of the whole stage.

## Interface
Parameters:
- DATA_W, 64: payload width in bits. Covers instruction, PC, immediate, operands and control bits packed by the instantiating stage.
- IDX_W, 4: ROB index width.
- RESET_PAYLOAD, '0: value of out_payload after reset and after the main entry is flushed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream may transfer this cycle.
- in_payload  in  DATA_W  upstream payload.
- in_rob_idx  in  IDX_W  ROB index of the upstream beat.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_payload  out  DATA_W  payload of the main entry.
- out_rob_idx  out  IDX_W  ROB index of the main entry.
- in_stall  in  1  global hold (e.g. d-cache miss).
- in_flush  in  1  redirect this cycle.
- in_flush_idx  in  IDX_W  ROB index of the redirecting instruction.
- out_occupancy  out  2  number of valid entries, 0..2.

## Operation
Storage:
- main entry: drives the out_* ports.
- skid entry: always younger than main; valid only if main is valid.

Handshakes:
- acc = in_valid && in_ready.
- drn = out_valid && out_ready && !in_stall.
- in_ready = !skid_valid && !in_stall. This is combinational on in_stall only, with no path from out_ready.
- out_valid = main_valid, registered.

Data movement, no flush:
- drn and skid valid: skid moves to main. If acc in the same cycle, the input goes to skid (unreachable, since in_ready is 0 while skid is valid).
- drn, skid empty, acc: input goes to main.
- drn only: main empties.
- acc only: input goes to main if main is empty, else to skid.
- in_stall: no acc, no drn, all state held.

Flush:
- in_flush has priority over in_stall.
- A beat handshaken (acc or drn) in the flush cycle still counts as transferred. The drained beat is gone. The accepted beat is subject to the flush rule below.
- Killed entries have valid cleared. A killed main entry also loads RESET_PAYLOAD and rob_idx 0.
- Age rule: idx is younger than f iff d = (idx − f) mod 2^IDX_W satisfies d != 0 && d < 2^(IDX_W−1). The redirecting instruction itself (d == 0) survives.
- Because skid is younger than main, "main killed" implies "skid killed". No compaction is ever needed. If main survives and skid is killed, only skid clears.

## Timing
- Reset (async, reset_n low):
  - main_valid = 0 and skid_valid = 0.
  - out_valid = 0, out_payload = RESET_PAYLOAD, out_rob_idx = 0, out_occupancy = 0.
  - in_ready = 1 as soon as in_stall = 0.
- Reset mid-operation discards both entries immediately. No beat is emitted after reset_n falls.
- Latency: input accepted at edge N appears on out_* after edge N. That is one cycle.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Backpressure: one out_ready = 0 cycle fills skid; in_ready drops the following cycle. No beat is lost or duplicated.
- Flush takes effect at the edge. The out_* ports reflect the surviving state in the next cycle.

## Configuration
- PIPE_REG_SELECTIVE_FLUSH_EN defined: age-based flush as above.
- Macro not defined: in_flush kills both entries and the accepted beat unconditionally, matching the legacy flush-everything behaviour. in_flush_idx is ignored.

## Structure
- Shared package pipe_pkg:
  - rob_idx_t typedef, sized by IDX_W.
  - age function is_younger(idx, f).
  - occupancy constants.
- One natural sub-module, rob_age_cmp: a combinational age comparator, instantiated three times for main, skid and incoming.
- The stage-specific payload struct stays in the stage that packs it.

## Test plan
- Stream 8 beats with out_ready = 1: outputs appear one cycle after each accept, in order, and out_occupancy never exceeds 1.
- Hold out_ready = 0 for 3 cycles while in_valid = 1: exactly 2 beats stored and in_ready = 0. On release, both drain in order with no loss.
- Assert in_stall with out_ready = 1 and in_valid = 1: no transfers and all outputs unchanged. in_stall plus in_flush together: the flush still applies.
- Macro defined, IDX_W = 4, main idx 14, skid idx 1, in_flush_idx = 15: skid is killed because of wrap-around and main survives. With flush idx 14 instead, main is kept (d = 0).
- Macro not defined, same state, any in_flush: both entries cleared, out_payload = RESET_PAYLOAD next cycle.
- reset_n pulsed low while occupancy = 2: outputs go to reset values asynchronously. After release, in_ready = 1 and the first new beat is emitted correctly.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types, occupancy codes and the ROB age helper used by pipe_reg_skid.
// The age rule treats ROB indices as a circular space split in half around the redirect point.
package pipe_pkg;

    localparam int unsigned ROB_IDX_W = 4;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // idx is younger than f when it lies in the forward half-window after f.
    function automatic logic is_younger(input logic [31:0] idx,
                                        input logic [31:0] f,
                                        input int unsigned w);
        logic [31:0] mask;
        logic [31:0] d;
        logic [31:0] half;
        mask = (32'd1 << w) - 32'd1;
        d    = (idx - f) & mask;
        half = 32'd1 << (w - 1);
        return (d != 32'd0) && (d < half);
    endfunction

endpackage

// File: rtl/rob_age_cmp.sv
// Combinational comparator: flags an instruction younger than the redirecting one.
module rob_age_cmp
    import pipe_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] flush_idx,
    output logic             younger
);

    assign younger = is_younger(32'(idx), 32'(flush_idx), IDX_W);

endmodule

// File: rtl/pipe_reg_skid.sv
// Two-entry elastic pipeline register (main + skid) with global stall and ROB-aware flush.
// Define PIPE_REG_SELECTIVE_FLUSH_EN for age-based flush; otherwise a flush kills everything.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W        = 64,
    parameter int unsigned       IDX_W         = 4,
    parameter logic [DATA_W-1:0] RESET_PAYLOAD = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [IDX_W-1:0]  in_rob_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_payload,
    output logic [IDX_W-1:0]  out_rob_idx,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic [IDX_W-1:0]  in_flush_idx,
    output logic [1:0]        out_occupancy
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [IDX_W-1:0]  main_idx, skid_idx;

    logic              nxt_main_valid, nxt_skid_valid;
    logic [DATA_W-1:0] nxt_main_data, nxt_skid_data;
    logic [IDX_W-1:0]  nxt_main_idx, nxt_skid_idx;
    logic              nxt_main_kill, nxt_skid_kill;

    logic acc, drn;
    logic kill_main, kill_skid, kill_in;

    // Handshakes: a beat moves on a port when valid && ready are both high at the
    // rising edge; in_ready never depends on out_ready, and in_stall freezes both ports.
    assign in_ready  = !skid_valid && !in_stall;
    assign out_valid = main_valid;
    assign acc       = in_valid && in_ready;
    assign drn       = main_valid && out_ready && !in_stall;

`ifdef PIPE_REG_SELECTIVE_FLUSH_EN
    logic younger_main, younger_skid, younger_in;

    rob_age_cmp #(.IDX_W(IDX_W)) u_age_main (
        .idx       (main_idx),
        .flush_idx (in_flush_idx),
        .younger   (younger_main)
    );

    rob_age_cmp #(.IDX_W(IDX_W)) u_age_skid (
        .idx       (skid_idx),
        .flush_idx (in_flush_idx),
        .younger   (younger_skid)
    );

    rob_age_cmp #(.IDX_W(IDX_W)) u_age_in (
        .idx       (in_rob_idx),
        .flush_idx (in_flush_idx),
        .younger   (younger_in)
    );

    assign kill_main = in_flush && younger_main;
    assign kill_skid = in_flush && younger_skid;
    assign kill_in   = in_flush && younger_in;
`else
    logic flush_idx_unused;
    assign flush_idx_unused = ^in_flush_idx;

    assign kill_main = in_flush;
    assign kill_skid = in_flush;
    assign kill_in   = in_flush;
`endif

    // Each entry carries the kill verdict of wherever its next content comes from.
    always_comb begin
        nxt_main_valid = main_valid;
        nxt_main_data  = main_data;
        nxt_main_idx   = main_idx;
        nxt_main_kill  = kill_main;
        nxt_skid_valid = skid_valid;
        nxt_skid_data  = skid_data;
        nxt_skid_idx   = skid_idx;
        nxt_skid_kill  = kill_skid;

        if (drn) begin
            if (skid_valid) begin
                nxt_main_valid = 1'b1;
                nxt_main_data  = skid_data;
                nxt_main_idx   = skid_idx;
                nxt_main_kill  = kill_skid;
                nxt_skid_valid = acc;
                nxt_skid_data  = in_payload;
                nxt_skid_idx   = in_rob_idx;
                nxt_skid_kill  = kill_in;
            end else if (acc) begin
                nxt_main_data  = in_payload;
                nxt_main_idx   = in_rob_idx;
                nxt_main_kill  = kill_in;
            end else begin
                nxt_main_valid = 1'b0;
            end
        end else if (acc) begin
            if (!main_valid) begin
                nxt_main_valid = 1'b1;
                nxt_main_data  = in_payload;
                nxt_main_idx   = in_rob_idx;
                nxt_main_kill  = kill_in;
            end else begin
                nxt_skid_valid = 1'b1;
                nxt_skid_data  = in_payload;
                nxt_skid_idx   = in_rob_idx;
                nxt_skid_kill  = kill_in;
            end
        end

        if (nxt_main_kill) begin
            nxt_main_valid = 1'b0;
            nxt_main_data  = RESET_PAYLOAD;
            nxt_main_idx   = '0;
        end
        if (nxt_skid_kill) begin
            nxt_skid_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= RESET_PAYLOAD;
            main_idx   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= RESET_PAYLOAD;
            skid_idx   <= '0;
        end else begin
            main_valid <= nxt_main_valid;
            main_data  <= nxt_main_data;
            main_idx   <= nxt_main_idx;
            skid_valid <= nxt_skid_valid;
            skid_data  <= nxt_skid_data;
            skid_idx   <= nxt_skid_idx;
        end
    end

    assign out_payload   = main_data;
    assign out_rob_idx   = main_idx;
    assign out_occupancy = (main_valid && skid_valid) ? OCC_FULL :
                           main_valid                 ? OCC_ONE  : OCC_EMPTY;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: streaming, backpressure, stall, flush (both builds) and reset.
// Expected values for the PIPE_REG_SELECTIVE_FLUSH_EN build are selected with the same macro.
module tb_pipe_reg_skid;

    localparam int unsigned       DATA_W = 64;
    localparam int unsigned       IDX_W  = 4;
    localparam logic [DATA_W-1:0] RST_PL = 64'hDEAD_BEEF;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_payload;
    logic [IDX_W-1:0]  in_rob_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_payload;
    logic [IDX_W-1:0]  out_rob_idx;
    logic              in_stall;
    logic              in_flush;
    logic [IDX_W-1:0]  in_flush_idx;
    logic [1:0]        out_occupancy;

    int n_checks;
    int n_fail;

    pipe_reg_skid #(
        .DATA_W        (DATA_W),
        .IDX_W         (IDX_W),
        .RESET_PAYLOAD (RST_PL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_payload    (in_payload),
        .in_rob_idx    (in_rob_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_payload   (out_payload),
        .out_rob_idx   (out_rob_idx),
        .in_stall      (in_stall),
        .in_flush      (in_flush),
        .in_flush_idx  (in_flush_idx),
        .out_occupancy (out_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] pl, input logic [IDX_W-1:0] idx);
        in_valid   = v;
        in_payload = pl;
        in_rob_idx = idx;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [DATA_W-1:0] pl,
                               input logic [IDX_W-1:0] idx, input logic [1:0] occ);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
        check_eq({tag, "_payload"}, out_payload, pl);
        check_eq({tag, "_idx"}, 64'(out_rob_idx), 64'(idx));
        check_eq({tag, "_occ"}, 64'(out_occupancy), 64'(occ));
    endtask

    // Builds main = (0xE, idx 14), skid = (0x1, idx 1) from an empty register.
    task automatic load_wrap_pair();
        out_ready = 1'b0;
        drive(1'b1, 64'hE, 4'd14);
        tick();
        drive(1'b1, 64'h1, 4'd1);
        tick();
        drive(1'b0, '0, '0);
        check_eq("wrap_setup_occ", 64'(out_occupancy), 64'd2);
    endtask

    task automatic drain_all();
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("drain_occ", 64'(out_occupancy), 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        in_stall     = 1'b0;
        in_flush     = 1'b0;
        in_flush_idx = '0;
        out_ready    = 1'b0;
        drive(1'b0, '0, '0);

        // Reset state.
        #12;
        check_state("reset", 1'b0, RST_PL, 4'd0, 2'd0);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        tick();

        // Streaming: one-cycle latency, in order, occupancy stays at 1.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 4'(i));
            tick();
            check_state($sformatf("stream%0d", i), 1'b1, 64'h100 + 64'(i), 4'(i), 2'd1);
        end
        drive(1'b0, '0, '0);
        tick();
        check_eq("stream_end_valid", 64'(out_valid), 64'd0);
        check_eq("stream_end_occ", 64'(out_occupancy), 64'd0);

        // Backpressure: out_ready low fills skid, then in_ready drops.
        out_ready = 1'b0;
        drive(1'b1, 64'h200, 4'd8);
        tick();
        check_eq("bp1_occ", 64'(out_occupancy), 64'd1);
        check_eq("bp1_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 64'h201, 4'd9);
        tick();
        check_eq("bp2_occ", 64'(out_occupancy), 64'd2);
        check_eq("bp2_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 64'h202, 4'd10);
        tick();
        check_state("bp3", 1'b1, 64'h200, 4'd8, 2'd2);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        tick();
        check_state("bp_rel1", 1'b1, 64'h201, 4'd9, 2'd1);
        tick();
        check_eq("bp_rel2_valid", 64'(out_valid), 64'd0);
        check_eq("bp_rel2_occ", 64'(out_occupancy), 64'd0);

        // Stall holds everything; stall plus flush still flushes.
        out_ready = 1'b0;
        drive(1'b1, 64'h300, 4'd3);
        tick();
        in_stall  = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'h301, 4'd4);
        #1;
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        check_state("stall_hold", 1'b1, 64'h300, 4'd3, 2'd1);
        in_flush     = 1'b1;
        in_flush_idx = 4'd2;
        tick();
        check_state("stall_flush", 1'b0, RST_PL, 4'd0, 2'd0);
        in_flush = 1'b0;
        in_stall = 1'b0;
        drive(1'b0, '0, '0);
        tick();

        // Wrap-around flush: flush idx 15 against main 14 / skid 1.
        load_wrap_pair();
        in_flush     = 1'b1;
        in_flush_idx = 4'd15;
        tick();
        in_flush = 1'b0;
`ifdef PIPE_REG_SELECTIVE_FLUSH_EN
        check_state("flush15", 1'b1, 64'hE, 4'd14, 2'd1);
`else
        check_state("flush15", 1'b0, RST_PL, 4'd0, 2'd0);
`endif
        drain_all();

        // Flush by the main entry's own index: main survives, skid dies.
        load_wrap_pair();
        in_flush     = 1'b1;
        in_flush_idx = 4'd14;
        tick();
        in_flush = 1'b0;
`ifdef PIPE_REG_SELECTIVE_FLUSH_EN
        check_state("flush14", 1'b1, 64'hE, 4'd14, 2'd1);
`else
        check_state("flush14", 1'b0, RST_PL, 4'd0, 2'd0);
`endif
        drain_all();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(1'b1, 64'h500, 4'd5);
        tick();
        drive(1'b1, 64'h501, 4'd6);
        tick();
        drive(1'b0, '0, '0);
        check_eq("prerst_occ", 64'(out_occupancy), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, RST_PL, 4'd0, 2'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check_eq("postrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 64'h600, 4'd7);
        tick();
        drive(1'b0, '0, '0);
        check_state("postrst_beat", 1'b1, 64'h600, 4'd7, 2'd1);
        tick();
        check_eq("postrst_drain", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
